// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder slice per clock, LSB first, WIDTH cycles per sum.
// Optional two's-complement overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             last_bit;
    logic             sum_bit;
    logic             carry_out;

    // Single full-adder slice on the current operand LSBs
    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_out = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? SHIFT : IDLE;
            SHIFT:      state_nxt = last_bit ? DONE : SHIFT;
            default:    state_nxt = IDLE;
        endcase
    end

    // Status flags registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == SHIFT);
            done <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= ci;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= {sum_bit, res[WIDTH-1:1]};
                    carry <= carry_out;
                    cnt   <= cnt + CNT_W'(1);
                    // Publish the result only on the final slice
                    if (last_bit) begin
                        s   <= {sum_bit, res[WIDTH-1:1]};
                        co  <= carry_out;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                        ovf <= carry ^ carry_out;
`endif
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): vector table, corner sequences, random vs. arithmetic model.
// Define BIT_SERIAL_ADDER_OVF_EN to also exercise the overflow output.
module tb_bit_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks;
    int errors;
    logic [WIDTH-1:0] prev_s;
    logic             prev_co;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
`ifdef BIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vci;
        logic [WIDTH-1:0] exp_s;
        logic             exp_co;
        logic             exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition and signed range test
    function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return (WIDTH+1)'(t);
    endfunction

    function automatic logic model_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       input logic c);
        int sx;
        int sy;
        int t;
        sx = x[WIDTH-1] ? int'(x) - (1 << WIDTH) : int'(x);
        sy = y[WIDTH-1] ? int'(y) - (1 << WIDTH) : int'(y);
        t  = sx + sy + int'(c);
        return (t > (1 << (WIDTH-1)) - 1) || (t < -(1 << (WIDTH-1)));
    endfunction

    task automatic launch(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
        @(negedge clk);
        start = 1'b1;
        a     = xa;
        b     = xb;
        ci    = xc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Follows an accepted start until done; glitch>0 pulses a zero-operand start in that busy cycle
    task automatic collect(input string name, input logic [WIDTH-1:0] es, input logic eco,
                           input logic eovf, input int glitch);
        int cyc;
        int busy_n;
        bit got;
        bit held_ok;
        cyc     = 0;
        busy_n  = 0;
        got     = 0;
        held_ok = 1;
        while (cyc < int'(WIDTH) + 6 && !got) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1;
            end else if (busy) begin
                busy_n++;
                if (s !== prev_s || co !== prev_co) held_ok = 0;
                if (busy_n == glitch) begin
                    start = 1'b1;
                    a     = '0;
                    b     = '0;
                    ci    = 1'b0;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
            end
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_latency"}, 32'(cyc), 32'(WIDTH + 1));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(WIDTH));
        chk({name, "_s_held"}, 32'(held_ok), 32'd1);
        chk({name, "_s"}, 32'(s), 32'(es));
        chk({name, "_co"}, 32'(co), 32'(eco));
        chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
        chk({name, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unreachable");
`endif
        prev_s  = es;
        prev_co = eco;
    endtask

    task automatic check_done_pulse(input string name);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({name, "_s_hold_idle"}, 32'(s), 32'(prev_s));
    endtask

    vec_t vecs[7];

    initial begin
        logic [WIDTH:0] ref_sum;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        bit               saw_done;

        checks  = 0;
        errors  = 0;
        prev_s  = '0;
        prev_co = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        ci      = 1'b0;
        rst_n   = 1'b0;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_s", 32'(s), 32'd0);
        chk("reset_co", 32'(co), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].va, vecs[i].vb, vecs[i].vci);
            collect($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_co, vecs[i].exp_ovf, 0);
            check_done_pulse($sformatf("vec%0d", i));
        end

        // start re-asserted mid-addition is ignored
        launch(8'h5A, 8'h3C, 1'b0);
        collect("ignore_mid", 8'h96, 1'b0, 1'b1, 3);
        check_done_pulse("ignore_mid");

        // Back-to-back: new start during the done cycle
        launch(8'h5A, 8'h3C, 1'b0);
        collect("b2b_first", 8'h96, 1'b0, 1'b1, 0);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h20;
        ci    = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        collect("b2b_second", 8'h30, 1'b0, 1'b0, 0);
        check_done_pulse("b2b_second");

        // Asynchronous reset in the middle of an addition
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (2 * WIDTH + 2) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("rst_no_done", 32'(saw_done), 32'd0);
        prev_s  = '0;
        prev_co = 1'b0;

        // start accepted on the first edge after reset release
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        ci    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        collect("first_edge", 8'h47, 1'b0, 1'b0, 0);
        check_done_pulse("first_edge");

        // Random operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra      = WIDTH'($urandom);
            rb      = WIDTH'($urandom);
            rc      = 1'($urandom);
            ref_sum = model_sum(ra, rb, rc);
            launch(ra, rb, rc);
            collect($sformatf("rnd%0d", i), ref_sum[WIDTH-1:0], ref_sum[WIDTH],
                    model_ovf(ra, rb, rc), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
